// File: rtl/hdmi_pattern_timing_gen_if.sv
// Video output bundle of the HDMI pattern/timing generator: syncs, data enable,
// pixel data, pixel position and frame marker.
interface hdmi_pattern_timing_gen_if #(
  parameter int BPC = 12,
  parameter int XW  = 12,
  parameter int YW  = 11
);
  logic              hs;
  logic              vs;
  logic              de;
  logic [3*BPC-1:0]  data;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              frame_start;

  modport master (
    output hs, vs, de, data, x, y, frame_start
  );

  modport slave (
    input hs, vs, de, data, x, y, frame_start
  );
endinterface

// File: rtl/hdmi_pattern_timing_gen.sv
// Video timing generator with built-in test patterns (colour bars, checkerboard,
// grey ramp, solid colour). All outputs are registered, one cycle behind the counters.
module hdmi_pattern_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int BPC      = 12,
  parameter int CHK_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [3*BPC-1:0]      color,
  hdmi_pattern_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYNC_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYNC_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  // Colour bar boundaries, resolved at elaboration so no divider is built.
  localparam logic [XW-1:0] BAR1 = XW'(1 * H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR2 = XW'(2 * H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR3 = XW'(3 * H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR4 = XW'(4 * H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR5 = XW'(5 * H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR6 = XW'(6 * H_ACTIVE / 8);
  localparam logic [XW-1:0] BAR7 = XW'(7 * H_ACTIVE / 8);

  typedef enum logic [1:0] {
    PAT_BARS   = 2'd0,
    PAT_CHECK  = 2'd1,
    PAT_RAMP   = 2'd2,
    PAT_SOLID  = 2'd3
  } pattern_e;

  logic [XW-1:0]     hcnt;
  logic [YW-1:0]     vcnt;
  pattern_e          mode_q;
  logic [3*BPC-1:0]  color_q;

  logic              at_origin;
  pattern_e          mode_eff;
  logic [3*BPC-1:0]  color_eff;
  logic              de_c;
  logic              hs_c;
  logic              vs_c;
  logic [2:0]        bar_idx;
  logic [2:0]        bar_rgb;
  logic [BPC-1:0]    ramp;
  logic              chk;
  logic [3*BPC-1:0]  pix_c;

  function automatic logic [3*BPC-1:0] expand_rgb(input logic [2:0] rgb);
    return {{BPC{rgb[2]}}, {BPC{rgb[1]}}, {BPC{rgb[0]}}};
  endfunction

  assign at_origin = (hcnt == '0) && (vcnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + YW'(1);
    end else begin
      hcnt <= hcnt + XW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= PAT_BARS;
      color_q <= '0;
    end else if (enable && at_origin) begin
      mode_q  <= pattern_e'(mode);
      color_q <= color;
    end
  end

  // Pixel (0,0) already uses the selection being latched for its frame.
  assign mode_eff  = at_origin ? pattern_e'(mode) : mode_q;
  assign color_eff = at_origin ? color : color_q;

  assign de_c = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign hs_c = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
  assign vs_c = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);

  assign ramp = BPC'(hcnt);
  assign chk  = hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2];

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bar_idx = 3'd0;
    if (hcnt >= BAR1) bar_idx = 3'd1;
    if (hcnt >= BAR2) bar_idx = 3'd2;
    if (hcnt >= BAR3) bar_idx = 3'd3;
    if (hcnt >= BAR4) bar_idx = 3'd4;
    if (hcnt >= BAR5) bar_idx = 3'd5;
    if (hcnt >= BAR6) bar_idx = 3'd6;
    if (hcnt >= BAR7) bar_idx = 3'd7;
  end

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    bar_rgb = 3'b000;
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    pix_c = '0;
    if (de_c) begin
      case (mode_eff)
        PAT_BARS:  pix_c = expand_rgb(bar_rgb);
        PAT_CHECK: pix_c = {3*BPC{~chk}};
        PAT_RAMP:  pix_c = {ramp, ramp, ramp};
        default:   pix_c = color_eff;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vid.hs          <= ~HS_POL;
      vid.vs          <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.data        <= '0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.frame_start <= 1'b0;
    end else if (!enable) begin
      vid.hs          <= ~HS_POL;
      vid.vs          <= ~VS_POL;
      vid.de          <= 1'b0;
      vid.data        <= '0;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.hs          <= hs_c ? HS_POL : ~HS_POL;
      vid.vs          <= vs_c ? VS_POL : ~VS_POL;
      vid.de          <= de_c;
      vid.data        <= pix_c;
      vid.x           <= hcnt;
      vid.y           <= vcnt;
      vid.frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_hdmi_pattern_timing_gen.sv
// Bench for hdmi_pattern_timing_gen on a small 24x8 raster: a cycle-count based
// reference model predicts every output, plus targeted pixel and timing checks.
module tb_hdmi_pattern_timing_gen;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 4,  V_FP = 1, V_SYNC = 1, V_BP = 2;
  localparam int BPC = 8, CHK_LOG2 = 2;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int XW = $clog2(H_TOTAL), YW = $clog2(V_TOTAL);

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] color;

  hdmi_pattern_timing_gen_if #(.BPC(BPC), .XW(XW), .YW(YW)) vid ();

  hdmi_pattern_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .BPC(BPC), .CHK_LOG2(CHK_LOG2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .mode  (mode),
    .color (color),
    .vid   (vid)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: t counts enabled cycles since the raster origin.
  int          t = 0;
  logic [1:0]  f_mode = 2'd0;
  logic [23:0] f_color = 24'h0;
  bit          o_en = 1'b0;
  int          o_x = 0, o_y = 0;
  logic        e_hs, e_vs, e_de, e_fs;
  logic [23:0] e_data;

  function automatic logic [23:0] bar_color(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] expect_pixel(input int px, input int py,
                                               input logic [1:0] m, input logic [23:0] c);
    logic [7:0] r;
    if (px >= H_ACTIVE || py >= V_ACTIVE) return 24'h0;
    case (m)
      2'd0: return bar_color(px * 8 / H_ACTIVE);
      2'd1: return ((((px >> CHK_LOG2) + (py >> CHK_LOG2)) % 2) == 0) ? 24'hFFFFFF : 24'h0;
      2'd2: begin
        r = 8'(px % 256);
        return {r, r, r};
      end
      default: return c;
    endcase
  endfunction

  // One clock: predict the outputs of this edge, advance, compare everything.
  task automatic step(input string name);
    if (!reset) begin
      t = 0; f_mode = 2'd0; f_color = 24'h0;
      o_en = 1'b0; o_x = 0; o_y = 0;
    end else if (!enable) begin
      t = 0; o_en = 1'b0; o_x = 0; o_y = 0;
    end else begin
      o_en = 1'b1;
      o_x  = t % H_TOTAL;
      o_y  = (t / H_TOTAL) % V_TOTAL;
      if (o_x == 0 && o_y == 0) begin
        f_mode  = mode;
        f_color = color;
      end
      t = (t + 1) % FRAME;
    end
    e_de   = o_en && (o_x < H_ACTIVE) && (o_y < V_ACTIVE);
    e_hs   = (o_en && o_x >= H_ACTIVE + H_FP && o_x < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
    e_vs   = (o_en && o_y >= V_ACTIVE + V_FP && o_y < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
    e_fs   = o_en && (o_x == 0) && (o_y == 0);
    e_data = o_en ? expect_pixel(o_x, o_y, f_mode, f_color) : 24'h0;
    @(posedge clock);
    #1;
    n_tests++;
    if ({vid.hs, vid.vs, vid.de, vid.frame_start, vid.data, vid.x, vid.y} !==
        {e_hs, e_vs, e_de, e_fs, e_data, XW'(o_x), YW'(o_y)}) begin
      n_fail++;
      $display("FAIL %s @%0t: got hs=%b vs=%b de=%b fs=%b data=%h x=%0d y=%0d, want hs=%b vs=%b de=%b fs=%b data=%h x=%0d y=%0d",
               name, $time, vid.hs, vid.vs, vid.de, vid.frame_start, vid.data, vid.x, vid.y,
               e_hs, e_vs, e_de, e_fs, e_data, o_x, o_y);
    end
  endtask

  // Advance until the model says pixel (x,y) is on the outputs (bounded).
  task automatic run_to(input int x, input int y, input string name);
    int n = 0;
    do begin
      step(name);
      n++;
    end while (!(o_en && o_x == x && o_y == y) && n < 2 * FRAME);
    n_tests++;
    if (!(o_en && o_x == x && o_y == y)) begin
      n_fail++;
      $display("FAIL %s: pixel (%0d,%0d) not reached within %0d cycles", name, x, y, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; mode = 2'd0; color = 24'h0;
    repeat (3) step("reset_hold");
    n_tests++;
    if ({vid.hs, vid.vs, vid.de, vid.frame_start, vid.data, vid.x, vid.y} !==
        {!HS_POL, !VS_POL, 1'b0, 1'b0, 24'h0, XW'(0), YW'(0)}) begin
      n_fail++;
      $display("FAIL reset_values: got hs=%b vs=%b de=%b fs=%b data=%h x=%0d y=%0d, want idle",
               vid.hs, vid.vs, vid.de, vid.frame_start, vid.data, vid.x, vid.y);
    end
    reset = 1'b1;
    repeat (2) step("idle_disabled");
  endtask

  task automatic test_timing();
    int de_cnt = 0, de_bad = 0, hs_cnt = 0, hs_bad = 0, vs_cnt = 0, vs_bad = 0;
    int fs_cnt = 0, fs_first = -1, fs_gap = -1;
    mode = 2'd0;
    enable = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step("timing");
      if (vid.de) begin
        de_cnt++;
        if (o_x >= H_ACTIVE || o_y >= V_ACTIVE) de_bad++;
      end
      if (vid.hs == HS_POL) begin
        hs_cnt++;
        if (o_x < 18 || o_x > 20) hs_bad++;
      end
      if (vid.vs == VS_POL) begin
        vs_cnt++;
        if (o_y != 5) vs_bad++;
      end
      if (vid.frame_start) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = c;
        else fs_gap = c - fs_first;
      end
    end
    n_tests++;
    if (de_cnt !== 2 * 64 || de_bad !== 0) begin
      n_fail++;
      $display("FAIL timing_de: got %0d de cycles (%0d misplaced), want 128 (0)", de_cnt, de_bad);
    end
    n_tests++;
    if (hs_cnt !== 2 * V_TOTAL * H_SYNC || hs_bad !== 0) begin
      n_fail++;
      $display("FAIL timing_hs: got %0d hs cycles (%0d outside x=18..20), want 48 (0)", hs_cnt, hs_bad);
    end
    n_tests++;
    if (vs_cnt !== 2 * H_TOTAL || vs_bad !== 0) begin
      n_fail++;
      $display("FAIL timing_vs: got %0d vs cycles (%0d off y=5), want 48 (0)", vs_cnt, vs_bad);
    end
    n_tests++;
    if (fs_cnt !== 2 || fs_first !== 0 || fs_gap !== FRAME) begin
      n_fail++;
      $display("FAIL timing_frame_start: got count=%0d first=%0d gap=%0d, want 2 0 192",
               fs_cnt, fs_first, fs_gap);
    end
  endtask

  task automatic test_bars();
    int          xs [9];
    logic [23:0] ev [9];
    xs = '{0, 1, 2, 3, 6, 7, 14, 15, 16};
    ev = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FF00,
           24'h00FF00, 24'h000000, 24'h000000, 24'h000000};
    mode = 2'd0;
    run_to(0, 0, "bars_sync");
    for (int i = 0; i < 9; i++) begin
      if (xs[i] != 0) run_to(xs[i], 0, "bars_seek");
      n_tests++;
      if (vid.data !== ev[i]) begin
        n_fail++;
        $display("FAIL bars_x%0d: got data=%h, want %h", xs[i], vid.data, ev[i]);
      end
    end
  endtask

  task automatic test_mode_switch();
    int          xs [5];
    int          ys [5];
    logic [23:0] ev [5];
    xs = '{8, 0, 4, 8, 12};
    ys = '{3, 0, 0, 0, 2};
    ev = '{24'hFF00FF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    mode = 2'd0;
    run_to(5, 2, "switch_seek");
    mode = 2'd1;
    for (int i = 0; i < 5; i++) begin
      run_to(xs[i], ys[i], "switch_seek");
      n_tests++;
      if (vid.data !== ev[i]) begin
        n_fail++;
        $display("FAIL mode_switch_(%0d,%0d): got data=%h, want %h", xs[i], ys[i], vid.data, ev[i]);
      end
    end
  endtask

  task automatic test_ramp_solid();
    int bad = 0, active = 0;
    mode = 2'd2;
    run_to(0, 0, "ramp_sync");
    run_to(7, 0, "ramp_seek");
    n_tests++;
    if (vid.data !== 24'h070707) begin
      n_fail++;
      $display("FAIL ramp_x7: got data=%h, want 070707", vid.data);
    end
    run_to(15, 3, "ramp_seek");
    n_tests++;
    if (vid.data !== 24'h0F0F0F) begin
      n_fail++;
      $display("FAIL ramp_x15: got data=%h, want 0F0F0F", vid.data);
    end
    mode = 2'd3;
    color = 24'h123456;
    run_to(0, 0, "solid_sync");
    for (int c = 0; c < FRAME; c++) begin
      if (c != 0) step("solid");
      if (e_de) begin
        active++;
        if (vid.data !== 24'h123456) bad++;
      end else if (vid.data !== 24'h0) begin
        bad++;
      end
    end
    n_tests++;
    if (bad !== 0 || active !== 64) begin
      n_fail++;
      $display("FAIL solid_frame: got %0d wrong pixels over %0d active, want 0 over 64", bad, active);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'd0;
    run_to(9, 2, "rstmid_seek");
    reset = 1'b0;
    #2;
    n_tests++;
    if ({vid.hs, vid.vs, vid.de, vid.frame_start, vid.data, vid.x, vid.y} !==
        {!HS_POL, !VS_POL, 1'b0, 1'b0, 24'h0, XW'(0), YW'(0)}) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got de=%b fs=%b data=%h x=%0d y=%0d, want idle",
               vid.de, vid.frame_start, vid.data, vid.x, vid.y);
    end
    repeat (2) step("rstmid_hold");
    reset = 1'b1;
    step("rstmid_restart");
    n_tests++;
    if ({vid.frame_start, vid.de, vid.x, vid.y, vid.data} !==
        {1'b1, 1'b1, XW'(0), YW'(0), 24'hFFFFFF}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got fs=%b de=%b x=%0d y=%0d data=%h, want 1 1 0 0 FFFFFF",
               vid.frame_start, vid.de, vid.x, vid.y, vid.data);
    end
  endtask

  task automatic test_enable_gap();
    int de_seen = 0;
    run_to(3, 1, "gap_seek");
    enable = 1'b0;
    repeat (10) begin
      step("gap_low");
      if (vid.de !== 1'b0) de_seen++;
    end
    n_tests++;
    if (de_seen !== 0) begin
      n_fail++;
      $display("FAIL enable_gap_de: got %0d cycles with de not low, want 0", de_seen);
    end
    enable = 1'b1;
    step("gap_resume");
    n_tests++;
    if ({vid.frame_start, vid.x, vid.y} !== {1'b1, XW'(0), YW'(0)}) begin
      n_fail++;
      $display("FAIL enable_resume: got fs=%b x=%0d y=%0d, want 1 0 0",
               vid.frame_start, vid.x, vid.y);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) color = 24'($urandom);
      enable = ($urandom_range(0, 399) != 0);
      step("random");
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_mode_switch();
    test_ramp_solid();
    test_reset_mid();
    test_enable_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
